// File: rtl/sram_param.sv
// Single-port byte-writable SRAM with a self-clearing power-up sequence and registered read port.
// Define SRAM_PARIDAD_EN to store and check one even-parity bit per byte.
module sram_param #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            CSram,
    input  logic [AW-1:0]   Direc,
    input  logic [DW-1:0]   Datain,
    input  logic            LeerMem,
    input  logic            EscrMem,
    input  logic [DW/8-1:0] HabByte,
    output logic [DW-1:0]   Dataout,
    output logic            DatoValido,
    output logic            Ocupado,
    output logic            ErrAcc,
    output logic            ErrPar
);
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {LIMPIA, LISTO} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   dataout_q, dataout_d;
    logic            valido_q, valido_d;
    logic            erracc_q, erracc_d;
    logic            errpar_q, errpar_d;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [NB-1:0]   wr_be;
    logic            rd_en;
    logic [DW-1:0]   rd_data;
    logic [NB-1:0]   par_err;

    // The clear sequence borrows the write port, so the memory only ever sees one writer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dataout_d = dataout_q;
        valido_d  = 1'b0;
        erracc_d  = 1'b0;
        errpar_d  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = Direc;
        wr_data   = Datain;
        wr_be     = HabByte;
        rd_en     = 1'b0;
        case (state_q)
            LIMPIA: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = '0;
                wr_be   = '1;
                cnt_d   = cnt_q + 1'b1;
                if (&cnt_q) state_d = LISTO;
            end
            LISTO: begin
                if (CSram) begin
                    if (LeerMem && EscrMem) erracc_d = 1'b1;
                    else if (EscrMem)       wr_en    = 1'b1;
                    else if (LeerMem)       rd_en    = 1'b1;
                end
            end
            default: state_d = LIMPIA;
        endcase
        if (rd_en) begin
            dataout_d = rd_data;
            valido_d  = 1'b1;
            errpar_d  = |par_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LIMPIA;
            cnt_q     <= '0;
            dataout_q <= '0;
            valido_q  <= 1'b0;
            erracc_q  <= 1'b0;
            errpar_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dataout_q <= dataout_d;
            valido_q  <= valido_d;
            erracc_q  <= erracc_d;
            errpar_q  <= errpar_d;
        end
    end

    // One independent array per byte lane keeps byte enables a plain per-lane write enable.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) lane_mem[wr_addr] <= wr_data[8*gi +: 8];
            end
            assign rd_data[8*gi +: 8] = lane_mem[Direc];
`ifdef SRAM_PARIDAD_EN
            logic lane_par [DEPTH];
            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) lane_par[wr_addr] <= ^wr_data[8*gi +: 8];
            end
            assign par_err[gi] = lane_par[Direc] ^ (^rd_data[8*gi +: 8]);
`else
            assign par_err[gi] = 1'b0;
`endif
        end
    endgenerate

    assign Dataout    = dataout_q;
    assign DatoValido = valido_q;
    assign Ocupado    = (state_q == LIMPIA);
    assign ErrAcc     = erracc_q;
    assign ErrPar     = errpar_q;
endmodule

// File: tb/tb_sram_param.sv
// Directed bench for sram_param (DW=32, AW=8): clear timing, byte writes, reads, errors, reset.
module tb_sram_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        CSram = 1'b0;
    logic [7:0]  Direc = '0;
    logic [31:0] Datain = '0;
    logic        LeerMem = 1'b0;
    logic        EscrMem = 1'b0;
    logic [3:0]  HabByte = '0;
    logic [31:0] Dataout;
    logic        DatoValido, Ocupado, ErrAcc, ErrPar;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    sram_param #(.DW(32), .AW(8)) dut (
        .clk(clk), .rst(rst), .CSram(CSram), .Direc(Direc), .Datain(Datain),
        .LeerMem(LeerMem), .EscrMem(EscrMem), .HabByte(HabByte),
        .Dataout(Dataout), .DatoValido(DatoValido), .Ocupado(Ocupado),
        .ErrAcc(ErrAcc), .ErrPar(ErrPar)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        CSram = 1'b0; LeerMem = 1'b0; EscrMem = 1'b0; HabByte = '0;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        CSram = 1'b1; LeerMem = rd; EscrMem = wr; Direc = a; Datain = d; HabByte = be;
    endtask

    // Counts edges until Ocupado drops, bounded so a stuck clear cannot hang the run.
    task automatic count_clear(output int cnt);
        cnt = 0;
        while (Ocupado && cnt < 400) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        #1;
        check("rst_ocupado", 32'(Ocupado), 32'd1);
        check("rst_dataout", Dataout, 32'h0);
        check("rst_valido", 32'(DatoValido), 32'd0);
        check("rst_erracc", 32'(ErrAcc), 32'd0);
        check("rst_errpar", 32'(ErrPar), 32'd0);
        step(); step();
        rst = 1'b0;

        // Conflicting request while clearing must be silent.
        repeat (10) step();
        req(1, 1, 8'h60, 32'hFFFFFFFF, 4'hF);
        step();
        check("busy_conflict_erracc", 32'(ErrAcc), 32'd0);
        check("busy_conflict_valido", 32'(DatoValido), 32'd0);
        idle();
        count_clear(n);
        check("clear_cycles", 32'(n + 11), 32'd256);

        req(1, 0, 8'h60, 32'h0, 4'h0);
        step();
        check("rd60_cleared", Dataout, 32'h0);
        check("rd60_valido", 32'(DatoValido), 32'd1);
        idle();
        step();
        check("valido_pulse_end", 32'(DatoValido), 32'd0);

        req(0, 1, 8'h60, 32'h00000001, 4'hF);
        step();
        check("wr_no_valido", 32'(DatoValido), 32'd0);
        req(1, 0, 8'h60, 32'h0, 4'h0);
        step();
        check("rd_after_wr1", Dataout, 32'h00000001);
        check("rd_after_wr1_valido", 32'(DatoValido), 32'd1);
        req(0, 1, 8'h60, 32'h00000003, 4'hF);
        step();
        check("wr_keeps_dataout", Dataout, 32'h00000001);
        req(1, 0, 8'h60, 32'h0, 4'h0);
        step();
        check("rd_after_wr3", Dataout, 32'h00000003);

        req(0, 1, 8'h10, 32'hAABBCCDD, 4'hF);
        step();
        req(0, 1, 8'h10, 32'h11223344, 4'b0101);
        step();
        req(1, 0, 8'h10, 32'h0, 4'h0);
        step();
        check("byte_merge", Dataout, 32'hAA22CC44);
        req(0, 1, 8'h10, 32'h00000000, 4'h0);
        step();
        req(1, 0, 8'h10, 32'h0, 4'h0);
        step();
        check("no_byte_enable", Dataout, 32'hAA22CC44);

        req(1, 1, 8'h60, 32'hFFFFFFFF, 4'hF);
        step();
        check("conflict_erracc", 32'(ErrAcc), 32'd1);
        check("conflict_valido", 32'(DatoValido), 32'd0);
        idle();
        step();
        check("conflict_erracc_pulse", 32'(ErrAcc), 32'd0);
        req(1, 0, 8'h60, 32'h0, 4'h0);
        step();
        check("conflict_no_write", Dataout, 32'h00000003);

        req(1, 0, 8'h10, 32'h0, 4'h0);
        CSram = 1'b0;
        step();
        check("cs_low_valido", 32'(DatoValido), 32'd0);
        check("cs_low_dataout", Dataout, 32'h00000003);

`ifdef SRAM_PARIDAD_EN
        dut.g_lane[2].lane_par[8'h60] = ~dut.g_lane[2].lane_par[8'h60];
        req(1, 0, 8'h60, 32'h0, 4'h0);
        step();
        check("par_flip_errpar", 32'(ErrPar), 32'd1);
        check("par_flip_valido", 32'(DatoValido), 32'd1);
        check("par_flip_data", Dataout, 32'h00000003);
        req(1, 0, 8'h61, 32'h0, 4'h0);
        step();
        check("par_ok_errpar", 32'(ErrPar), 32'd0);
`else
        req(1, 0, 8'h60, 32'h0, 4'h0);
        step();
        check("no_par_errpar", 32'(ErrPar), 32'd0);
`endif

        // Reset in the middle of a read.
        req(1, 0, 8'h10, 32'h0, 4'h0);
        step();
        check("pre_rst_read", Dataout, 32'hAA22CC44);
        rst = 1'b1;
        idle();
        #1;
        check("mid_rst_dataout", Dataout, 32'h0);
        check("mid_rst_valido", 32'(DatoValido), 32'd0);
        check("mid_rst_ocupado", 32'(Ocupado), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        count_clear(n);
        check("reclear_cycles", 32'(n), 32'd256);
        req(1, 0, 8'h10, 32'h0, 4'h0);
        step();
        check("reclear_data", Dataout, 32'h0);
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sram_param.md
SRAM_PARAM -- requirements
Module: sram_param

Interface
REQ-001 Parameter DW, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 8: address width; depth SHALL be 2**AW words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 CSram  input  1  chip select; no access is accepted while low.
REQ-006 Direc  input  AW  word address.
REQ-007 Datain  input  DW  write data.
REQ-008 LeerMem  input  1  read request.
REQ-009 EscrMem  input  1  write request.
REQ-010 HabByte  input  DW/8  byte write enables; bit i covers Datain[8i+7:8i].
REQ-011 Dataout  output  DW  registered read data.
REQ-012 DatoValido  output  1  one-cycle pulse marking Dataout as fresh.
REQ-013 Ocupado  output  1  high while the clear sequence runs; requests are ignored.
REQ-014 ErrAcc  output  1  one-cycle pulse on an illegal request.
REQ-015 ErrPar  output  1  parity error flag, qualified by DatoValido.

Function
REQ-016 The FSM SHALL have exactly two states: LIMPIA (clear) and LISTO (ready).
REQ-017 In LIMPIA, the block SHALL write 0 to word Cnt each cycle, with Cnt running 0..2**AW-1, and hold Ocupado=1.
REQ-018 After the write to word 2**AW-1, the FSM SHALL go to LISTO, so Ocupado falls exactly 2**AW cycles after reset release.
REQ-019 In LISTO, an accepted access SHALL have CSram=1 and exactly one of LeerMem/EscrMem high.
REQ-020 Write: on the edge, each byte i with HabByte[i]=1 SHALL update; other bytes SHALL keep their value; DatoValido SHALL stay 0.
REQ-021 Read: Dataout SHALL take mem[Direc] on the accepting edge (latency 1), with DatoValido=1 for exactly that following cycle.
REQ-022 Dataout SHALL hold its last read value between reads; writes SHALL never change Dataout.
REQ-023 LeerMem=1 and EscrMem=1 with CSram=1 in LISTO SHALL be rejected: no memory change, no DatoValido, ErrAcc=1 for one cycle.
REQ-024 Any request during LIMPIA or with CSram=0 SHALL be ignored silently, with ErrAcc=0.
REQ-025 A read issued the cycle after a write to the same address SHALL return the newly written data.
REQ-026 A read of an address with all HabByte written 0 SHALL return the previous contents unchanged.

Reset
REQ-027 Asserting rst at any time, including mid-clear or mid-read, SHALL immediately force: state=LIMPIA, Cnt=0, Dataout=0, DatoValido=0, ErrAcc=0, ErrPar=0, Ocupado=1.
REQ-028 Memory contents SHALL be defined only through the clear sequence, not by reset itself.

Configuration
REQ-029 Macro SRAM_PARIDAD_EN, when defined, SHALL store one even-parity bit per byte, set on write and on clear.
REQ-030 With SRAM_PARIDAD_EN defined, each read SHALL recompute parity; ErrPar SHALL be 1 with DatoValido if any byte mismatches; Dataout SHALL still present the stored data.
REQ-031 Without SRAM_PARIDAD_EN, no parity storage SHALL exist and ErrPar SHALL be constant 0.

Verification (DW=32, AW=8)
REQ-032 Release rst -> Ocupado=1 for exactly 256 cycles, then 0; read of 0x60 -> Dataout=0x00000000, DatoValido one cycle.
REQ-033 Write 0x60=0x00000001 with HabByte=4'hF, then read 0x60 on the next cycle -> Dataout=0x00000001 one cycle after the read; then write 0x00000003 and read -> 0x00000003.
REQ-034 Write 0x10=0xAABBCCDD, then write 0x10=0x11223344 with HabByte=4'b0101, then read -> 0xAA22CC44.
REQ-035 Assert LeerMem=EscrMem=1 at 0x60 with Datain=0xFFFFFFFF -> ErrAcc pulses once, no DatoValido, and a later read still returns the prior value; the same request issued during Ocupado -> no ErrAcc.
REQ-036 Assert rst mid-read -> Dataout=0 and DatoValido=0 immediately; Ocupado=1 and the clear sequence restarts from word 0.
REQ-037 With SRAM_PARIDAD_EN, force-flip the stored parity bit of byte 2 at 0x60, then read -> ErrPar=1 with DatoValido; a read of 0x61 -> ErrPar=0.
